taitosj_pf_fetch: RTL and testbench



---
 rtl/taitosj_pf_pkg.sv | 38 +++
 rtl/taitosj_pf_shifter.sv | 51 +++++
 rtl/taitosj_pf_fetch.sv | 121 ++++++++++++
 tb/tb_taitosj_pf_fetch.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/taitosj_pf_pkg.sv
// Shared types and constants for the Taito SJ playfield tile fetch / serializer.
// The optional per-column scroll is controlled by TAITOSJ_PF_COLSCROLL_EN in the top module.
package taitosj_pf_pkg;

    localparam int PF_CELL_W = 8;
    localparam int PF_PLANES = 3;
    localparam int PF_COLS   = 32;
    localparam int PF_COL_W  = $clog2(PF_COLS);

    localparam logic [2:0] PH_CS   = 3'd0;
    localparam logic [2:0] PH_MAP  = 3'd1;
    localparam logic [2:0] PH_GFX  = 3'd2;
    localparam logic [2:0] PH_PEND = 3'd3;
    localparam logic [2:0] PH_RDY  = 3'd7;

    typedef enum logic [2:0] {
        S_CS,
        S_MAP,
        S_GFX,
        S_PEND,
        S_IDLE
    } pf_state_t;

    // The fetch state is a pure function of the beam phase, so a jump in SB_H
    // resynchronises the pipeline on the very next edge.
    function automatic pf_state_t phase_state(input logic [2:0] p);
        pf_state_t st;
        case (p)
            PH_CS:   st = S_CS;
            PH_MAP:  st = S_MAP;
            PH_GFX:  st = S_GFX;
            PH_PEND: st = S_PEND;
            default: st = S_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/taitosj_pf_shifter.sv
// Three playfield plane shift registers plus the registered, blank-gated pixel output.
module pf_shifter
    import taitosj_pf_pkg::*;
(
    input  logic                              clk,
    input  logic                              srst,
    input  logic                              load,
    input  logic                              blank,
    input  logic [PF_PLANES*PF_CELL_W-1:0]    load_data,
    output logic [PF_PLANES-1:0]              pix,
    output logic                              opaque
);

    logic [PF_PLANES-1:0] pixel;
    logic [PF_PLANES-1:0] pix_reg;
    logic                 opaque_reg;

    genvar gi;
    generate
        for (gi = 0; gi < PF_PLANES; gi++) begin : g_plane
            logic [PF_CELL_W-1:0] shift_reg;

            always_ff @(posedge clk) begin
                if (srst) begin
                    shift_reg <= '0;
                end else if (load) begin
                    shift_reg <= load_data[gi*PF_CELL_W +: PF_CELL_W];
                end else begin
                    shift_reg <= {shift_reg[PF_CELL_W-2:0], 1'b0};
                end
            end

            // Bit 7 is the leftmost pixel of the cell.
            assign pixel[gi] = shift_reg[PF_CELL_W-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            pix_reg    <= '0;
            opaque_reg <= 1'b0;
        end else begin
            pix_reg    <= blank ? '0 : pixel;
            opaque_reg <= !blank && (|pixel);
        end
    end

    assign pix    = pix_reg;
    assign opaque = opaque_reg;

endmodule

// File: rtl/taitosj_pf_fetch.sv
// Playfield 8-cycle tile fetch pipeline (column scroll -> tile map -> pattern) feeding pf_shifter.
// Define TAITOSJ_PF_COLSCROLL_EN to enable per-column vertical scroll from the CS RAM.
module taitosj_pf_fetch
    import taitosj_pf_pkg::*;
#(
    parameter int CS_LAT = 1
) (
    input  logic        clkm_6MHZ,
    input  logic        RESET,
    input  logic [7:0]  SB_H,
    input  logic [7:0]  SB_V,
    input  logic        HBL,
    input  logic        VBL,
    input  logic [7:0]  SCRX,
    input  logic [7:0]  SCRY,
    output logic [4:0]  CS_ADDR,
    input  logic [7:0]  CS_DATA,
    output logic [9:0]  VRAM_ADDR,
    input  logic [7:0]  VRAM_DATA,
    output logic [10:0] GFX_ADDR,
    input  logic [23:0] GFX_DATA,
    output logic [2:0]  PF_PIX,
    output logic        PF_OPAQUE
);

    generate
        if (CS_LAT != 1) begin : g_cs_lat_check
            $error("taitosj_pf_fetch: only CS_LAT = 1 is supported");
        end
    endgenerate

    logic [2:0]           phase;
    pf_state_t            fetch_state;
    logic [PF_COL_W-1:0]  col_next;
    logic [PF_COL_W-1:0]  col_reg;
    logic [PF_COL_W-1:0]  cs_addr_next;
    logic [PF_COL_W-1:0]  cs_addr_reg;
    logic [7:0]           y_next;
    logic [7:0]           yrow_reg;
    logic [9:0]           vram_addr_reg;
    logic [10:0]          gfx_addr_reg;
    logic [23:0]          pend_reg;
    logic [23:0]          rdy_reg;
    logic                 cell_ok_reg;
    logic                 shift_load;

    assign phase       = SB_H[2:0];
    assign fetch_state = phase_state(phase);
    assign col_next    = SB_H[7:3] + 5'd1 + SCRX[7:3];

`ifdef TAITOSJ_PF_COLSCROLL_EN
    assign cs_addr_next = col_next;
    assign y_next       = SB_V + SCRY + CS_DATA;
`else
    logic cs_data_unused;
    assign cs_data_unused = ^CS_DATA;
    assign cs_addr_next   = '0;
    assign y_next         = SB_V + SCRY;
`endif

    // cell_ok_reg marks a fetch that started at p=0 after reset; a cell cut
    // short by reset therefore carries zeros instead of stale pattern data.
    always_ff @(posedge clkm_6MHZ) begin
        if (RESET) begin
            col_reg       <= '0;
            cs_addr_reg   <= '0;
            yrow_reg      <= '0;
            vram_addr_reg <= '0;
            gfx_addr_reg  <= '0;
            pend_reg      <= '0;
            cell_ok_reg   <= 1'b0;
        end else begin
            case (fetch_state)
                S_CS: begin
                    col_reg     <= col_next;
                    cs_addr_reg <= cs_addr_next;
                    cell_ok_reg <= 1'b1;
                end
                S_MAP: begin
                    yrow_reg      <= y_next;
                    vram_addr_reg <= {y_next[7:3], col_reg};
                end
                S_GFX: begin
                    gfx_addr_reg <= {VRAM_DATA, yrow_reg[2:0]};
                end
                S_PEND: begin
                    pend_reg <= cell_ok_reg ? GFX_DATA : '0;
                end
                default: begin
                end
            endcase
        end
    end

    // The shifter samples rdy_reg before this copy, so a fine offset of 7
    // still shows the previous cell on the shared edge.
    always_ff @(posedge clkm_6MHZ) begin
        if (RESET) begin
            rdy_reg <= '0;
        end else if (phase == PH_RDY) begin
            rdy_reg <= pend_reg;
        end
    end

    assign shift_load = (phase == SCRX[2:0]);

    pf_shifter u_shifter (
        .clk       (clkm_6MHZ),
        .srst      (RESET),
        .load      (shift_load),
        .blank     (HBL | VBL),
        .load_data (rdy_reg),
        .pix       (PF_PIX),
        .opaque    (PF_OPAQUE)
    );

    assign CS_ADDR   = cs_addr_reg;
    assign VRAM_ADDR = vram_addr_reg;
    assign GFX_ADDR  = gfx_addr_reg;

endmodule

// File: tb/tb_taitosj_pf_fetch.sv
// Self-checking bench for taitosj_pf_fetch: per-pixel scoreboard against a timing model plus directed scenarios.
module tb_taitosj_pf_fetch;

`ifdef TAITOSJ_PF_COLSCROLL_EN
    localparam bit COLSCROLL = 1'b1;
`else
    localparam bit COLSCROLL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        RESET;
    logic [7:0]  SB_H, SB_V, SCRX, SCRY;
    logic        HBL, VBL;
    logic [4:0]  CS_ADDR;
    logic [7:0]  CS_DATA;
    logic [9:0]  VRAM_ADDR;
    logic [7:0]  VRAM_DATA;
    logic [10:0] GFX_ADDR;
    logic [23:0] GFX_DATA;
    logic [2:0]  PF_PIX;
    logic        PF_OPAQUE;

    logic [7:0]  cs_mem [32];
    logic [7:0]  vram   [1024];
    logic [23:0] gfx    [2048];

    always #5 clk = ~clk;

    assign CS_DATA   = cs_mem[CS_ADDR];
    assign VRAM_DATA = vram[VRAM_ADDR];
    assign GFX_DATA  = gfx[GFX_ADDR];

    taitosj_pf_fetch #(.CS_LAT(1)) dut (
        .clkm_6MHZ (clk),
        .RESET     (RESET),
        .SB_H      (SB_H),
        .SB_V      (SB_V),
        .HBL       (HBL),
        .VBL       (VBL),
        .SCRX      (SCRX),
        .SCRY      (SCRY),
        .CS_ADDR   (CS_ADDR),
        .CS_DATA   (CS_DATA),
        .VRAM_ADDR (VRAM_ADDR),
        .VRAM_DATA (VRAM_DATA),
        .GFX_ADDR  (GFX_ADDR),
        .GFX_DATA  (GFX_DATA),
        .PF_PIX    (PF_PIX),
        .PF_OPAQUE (PF_OPAQUE)
    );

    typedef struct {
        int         h;
        logic [2:0] pix;
    } exp_t;

    exp_t       sb_q [$];
    int         checks = 0;
    int         errors = 0;
    int         start_h = 0;
    logic [2:0] pix_log [256];

    function automatic logic [4:0] model_col(input int c);
        return 5'((c >> 3) + 1 + int'(SCRX[7:3]));
    endfunction

    function automatic logic [7:0] model_y(input logic [4:0] col);
        logic [7:0] y;
        y = SB_V + SCRY;
        if (COLSCROLL) y = y + cs_mem[col];
        return y;
    endfunction

    // Pixel shown after edge h: data loaded at the last p==fine edge before h,
    // which is the cell fetched in the 8-cycle window preceding that load.
    function automatic logic [2:0] model_pix(input int h);
        int t, off, l, c, i;
        logic [4:0]  col;
        logic [7:0]  y;
        logic [23:0] d;
        if (HBL || VBL) return 3'd0;
        t = h - 1;
        if (t < start_h) return 3'd0;
        off = ((t - int'(SCRX[2:0])) % 8 + 8) % 8;
        l = t - off;
        if (l < start_h) return 3'd0;
        c = (l / 8) * 8 - 8;
        if (c < start_h) return 3'd0;
        col = model_col(c);
        y = model_y(col);
        d = gfx[{vram[{y[7:3], col}], y[2:0]}];
        i = 7 - off;
        return {d[16+i], d[8+i], d[i]};
    endfunction

    task automatic tick(input int h);
        exp_t       e;
        logic [4:0] col;
        logic [7:0] y;
        SB_H  = 8'(h);
        e.h   = h;
        e.pix = RESET ? 3'd0 : model_pix(h);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        pix_log[h % 256] = PF_PIX;
        checks++;
        if (PF_PIX !== e.pix || PF_OPAQUE !== (|e.pix)) begin
            errors++;
            $display("FAIL pixel h=%0d: PF_PIX=%0d PF_OPAQUE=%b, expected %0d/%b",
                     e.h, PF_PIX, PF_OPAQUE, e.pix, |e.pix);
        end
        if (RESET) begin
            checks++;
            if (CS_ADDR !== 5'd0 || VRAM_ADDR !== 10'd0 || GFX_ADDR !== 11'd0) begin
                errors++;
                $display("FAIL reset_addr h=%0d: CS=%h VRAM=%h GFX=%h, expected all 0",
                         h, CS_ADDR, VRAM_ADDR, GFX_ADDR);
            end
        end else if ((h & ~7) >= start_h) begin
            col = model_col(h);
            y   = model_y(col);
            case (h & 7)
                0: begin
                    checks++;
                    if (CS_ADDR !== (COLSCROLL ? col : 5'd0)) begin
                        errors++;
                        $display("FAIL cs_addr h=%0d: got %h, expected %h",
                                 h, CS_ADDR, COLSCROLL ? col : 5'd0);
                    end
                end
                1: begin
                    checks++;
                    if (VRAM_ADDR !== {y[7:3], col}) begin
                        errors++;
                        $display("FAIL vram_addr h=%0d: got %h, expected %h", h, VRAM_ADDR, {y[7:3], col});
                    end
                end
                2: begin
                    checks++;
                    if (GFX_ADDR !== {vram[{y[7:3], col}], y[2:0]}) begin
                        errors++;
                        $display("FAIL gfx_addr h=%0d: got %h, expected %h",
                                 h, GFX_ADDR, {vram[{y[7:3], col}], y[2:0]});
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick(254);
        tick(255);
        RESET = 1'b0;
        start_h = 0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++)   cs_mem[i] = 8'h00;
        for (int i = 0; i < 1024; i++) vram[i]   = 8'h00;
        for (int i = 0; i < 2048; i++) gfx[i]    = 24'h0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++)   cs_mem[i] = 8'($urandom);
        for (int i = 0; i < 1024; i++) vram[i]   = 8'($urandom);
        for (int i = 0; i < 2048; i++) gfx[i]    = 24'($urandom);
    endtask

    task automatic check_log(input string name, input int h, input logic [2:0] exp);
        checks++;
        if (pix_log[h] !== exp) begin
            errors++;
            $display("FAIL %s h=%0d: PF_PIX=%0d, expected %0d", name, h, pix_log[h], exp);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) tick(200 + i);
        RESET = 1'b0;
        $display("test_reset: done (checks=%0d errors=%0d)", checks, errors);
    endtask

    task automatic test_basic();
        clear_mem();
        vram[10'h001] = 8'h12;
        gfx[{8'h12, 3'd0}] = 24'hFF0000;
        SCRX = 8'h00; SCRY = 8'h00; SB_V = 8'h00;
        do_reset();
        for (int h = 0; h < 40; h++) tick(h);
        for (int h = 9; h <= 16; h++) check_log("basic_run", h, 3'd4);
        check_log("basic_before", 8, 3'd0);
        check_log("basic_after", 17, 3'd0);
        $display("test_basic: done (checks=%0d errors=%0d)", checks, errors);
    endtask

    task automatic test_fine_scroll();
        SCRX = 8'h05;
        do_reset();
        for (int h = 0; h < 40; h++) tick(h);
        for (int h = 14; h <= 21; h++) check_log("fine5_run", h, 3'd4);
        check_log("fine5_before", 13, 3'd0);
        check_log("fine5_after", 22, 3'd0);
        $display("test_fine_scroll: done (checks=%0d errors=%0d)", checks, errors);
    endtask

    task automatic test_fine7_boundary();
        vram[10'h002] = 8'h34;
        gfx[{8'h34, 3'd0}] = 24'h0000FF;
        SCRX = 8'h07;
        do_reset();
        for (int h = 0; h < 48; h++) tick(h);
        check_log("fine7_before", 15, 3'd0);
        for (int h = 16; h <= 23; h++) check_log("fine7_cell1", h, 3'd4);
        for (int h = 24; h <= 31; h++) check_log("fine7_cell2", h, 3'd1);
        check_log("fine7_after", 32, 3'd0);
        $display("test_fine7_boundary: done (checks=%0d errors=%0d)", checks, errors);
    endtask

    task automatic test_colscroll();
        clear_mem();
        cs_mem[1] = 8'hF8;
        vram[{5'd3, 5'd1}] = 8'h21;
        vram[{5'd4, 5'd1}] = 8'h42;
        gfx[{8'h21, 3'd0}] = 24'h00FF00;
        gfx[{8'h42, 3'd0}] = 24'h0000FF;
        SCRX = 8'h00; SCRY = 8'h10; SB_V = 8'h10;
        do_reset();
        tick(0);
        checks++;
        if (CS_ADDR !== (COLSCROLL ? 5'd1 : 5'd0)) begin
            errors++;
            $display("FAIL colscroll_cs_addr: got %0d, expected %0d", CS_ADDR, COLSCROLL ? 1 : 0);
        end
        tick(1);
        checks++;
        if (VRAM_ADDR !== {(COLSCROLL ? 5'd3 : 5'd4), 5'd1}) begin
            errors++;
            $display("FAIL colscroll_row: VRAM_ADDR=%h, expected row %0d col 1",
                     VRAM_ADDR, COLSCROLL ? 3 : 4);
        end
        tick(2);
        checks++;
        if (GFX_ADDR !== {(COLSCROLL ? 8'h21 : 8'h42), 3'd0}) begin
            errors++;
            $display("FAIL colscroll_gfx: GFX_ADDR=%h, expected %h",
                     GFX_ADDR, {(COLSCROLL ? 8'h21 : 8'h42), 3'd0});
        end
        for (int h = 3; h < 24; h++) tick(h);
        check_log("colscroll_pix", 9, COLSCROLL ? 3'd2 : 3'd1);
        SB_V = 8'h00; SCRY = 8'h00;
        $display("test_colscroll: done (checks=%0d errors=%0d)", checks, errors);
    endtask

    task automatic test_blank();
        fill_random();
        for (int i = 0; i < 2048; i++) gfx[i] = 24'hFFFFFF;
        SCRX = 8'($urandom);
        do_reset();
        for (int h = 0; h < 64; h++) begin
            HBL = (h < 24);
            VBL = (h >= 40 && h < 48);
            tick(h);
        end
        HBL = 1'b0; VBL = 1'b0;
        check_log("blank_hbl", 20, 3'd0);
        check_log("blank_vbl", 44, 3'd0);
        check_log("blank_open", 36, 3'd7);
        $display("test_blank: done (checks=%0d errors=%0d)", checks, errors);
    endtask

    task automatic test_reset_midcell();
        fill_random();
        SCRX = {5'($urandom), 3'd0};
        do_reset();
        for (int h = 0; h < 43; h++) tick(h);
        RESET = 1'b1;
        tick(43);
        tick(44);
        RESET = 1'b0;
        start_h = 45;
        for (int h = 45; h < 90; h++) tick(h);
        for (int h = 45; h <= 56; h++) check_log("midreset_partial", h, 3'd0);
        $display("test_reset_midcell: done (checks=%0d errors=%0d)", checks, errors);
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) begin
            fill_random();
            SCRX = 8'($urandom);
            SCRY = 8'($urandom);
            SB_V = 8'($urandom);
            do_reset();
            for (int h = 0; h < 256; h++) begin
                HBL = (h >= 232);
                VBL = 1'b0;
                tick(h);
            end
            HBL = 1'b0;
            $display("test_random line %0d: SCRX=%h SCRY=%h SB_V=%h (checks=%0d errors=%0d)",
                     n, SCRX, SCRY, SB_V, checks, errors);
        end
    endtask

    initial begin
        RESET = 1'b1;
        SB_H = 8'h00; SB_V = 8'h00; SCRX = 8'h00; SCRY = 8'h00;
        HBL = 1'b0; VBL = 1'b0;
        clear_mem();
        for (int i = 0; i < 256; i++) pix_log[i] = 3'd0;
        test_reset();
        test_basic();
        test_fine_scroll();
        test_fine7_boundary();
        test_colscroll();
        test_blank();
        test_reset_midcell();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
